// File: rtl/hex_display_scheduler_if.sv
// Write-beat channel from one requester into the hex display scheduler.
// The requester drives the beat (valid, digit, value, blank); the scheduler
// answers with ready while that requester owns the display.
interface hex_display_scheduler_if;
    logic       valid;
    logic       ready;
    logic [2:0] digit;
    logic [3:0] value;
    logic       blank;

    modport master (output valid, digit, value, blank, input ready);
    modport slave  (input valid, digit, value, blank, output ready);
endinterface

// File: rtl/hex_display_scheduler.sv
// Two-requester round-robin scheduler for a six-digit seven-segment display.
// A requester is granted ownership, streams up to MAX_BURST beats, and each
// legal beat updates one digit's nibble/blank registers. Segment outputs are
// a combinational decode of those registers.
module hex_display_scheduler #(
    parameter int         MAX_BURST  = 6,
    parameter logic [6:0] BLANK_CODE = 7'h7F
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    hex_display_scheduler_if.slave        req0,
    hex_display_scheduler_if.slave        req1,
    output logic [6:0]                    hex0,
    output logic [6:0]                    hex1,
    output logic [6:0]                    hex2,
    output logic [6:0]                    hex3,
    output logic [6:0]                    hex4,
    output logic [6:0]                    hex5,
    output logic [1:0]                    owner,
    output logic                          err_pulse
);
    localparam int         NUM_DIGITS  = 6;
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    // The state encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       last_q,  last_d;   // 0: requester0 served last, 1: requester1
    logic       err_q,   err_d;
    logic [3:0] value_q [NUM_DIGITS];
    logic [3:0] value_d [NUM_DIGITS];
    logic       blank_q [NUM_DIGITS];
    logic       blank_d [NUM_DIGITS];

    logic       accept;
    logic [2:0] beat_digit;
    logic [3:0] beat_value;
    logic       beat_blank;
    logic [6:0] hex_seg [NUM_DIGITS];

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Readies depend only on ownership, so they can never both be high.
    assign req0.ready = (state_q == OWN0);
    assign req1.ready = (state_q == OWN1);
    assign owner      = state_q;
    assign err_pulse  = err_q;

    // Beat from whichever requester currently owns the display.
    always_comb begin
        accept     = (req0.valid && req0.ready) || (req1.valid && req1.ready);
        beat_digit = (state_q == OWN1) ? req1.digit : req0.digit;
        beat_value = (state_q == OWN1) ? req1.value : req0.value;
        beat_blank = (state_q == OWN1) ? req1.blank : req0.blank;
    end

    // Arbitration, burst counting and digit register updates.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        err_d   = 1'b0;
        value_d = value_q;
        blank_d = blank_q;

        case (state_q)
            IDLE: begin
                if (req0.valid && req1.valid) begin
                    state_d = last_q ? OWN0 : OWN1;
                    count_d = 4'd0;
                end else if (req0.valid) begin
                    state_d = OWN0;
                    count_d = 4'd0;
                end else if (req1.valid) begin
                    state_d = OWN1;
                    count_d = 4'd0;
                end
            end
            OWN0, OWN1: begin
                if (!accept) begin
                    // Owner dropped valid: release without recording a beat.
                    state_d = IDLE;
                    last_d  = (state_q == OWN1);
                end else begin
                    count_d = count_q + 4'd1;
                    if (count_q + 4'd1 == BURST_LIMIT) begin
                        state_d = IDLE;
                        last_d  = (state_q == OWN1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Illegal digits still count as beats but only raise the error pulse.
        if (accept) begin
            if (beat_digit > 3'd5) begin
                err_d = 1'b1;
            end else begin
                blank_d[beat_digit] = beat_blank;
                if (!beat_blank) begin
                    value_d[beat_digit] = beat_value;
                end
            end
        end
    end

    // State and register file update; reset overrides any in-flight beat.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                value_q[i] <= 4'd0;
                blank_q[i] <= 1'b1;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            err_q   <= err_d;
            value_q <= value_d;
            blank_q <= blank_d;
        end
    end

    // Per-digit segment decode.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign hex_seg[gi] = blank_q[gi] ? BLANK_CODE : seg_decode(value_q[gi]);
        end
    endgenerate

    assign hex0 = hex_seg[0];
    assign hex1 = hex_seg[1];
    assign hex2 = hex_seg[2];
    assign hex3 = hex_seg[3];
    assign hex4 = hex_seg[4];
    assign hex5 = hex_seg[5];
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler: arbitration, burst limit,
// digit decode, error pulse and mid-burst reset.
module tb_hex_display_scheduler;
    logic       clk_clk;
    logic       reset_reset_n;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [1:0] owner;
    logic       err_pulse;

    int checks = 0;
    int errors = 0;

    hex_display_scheduler_if req0_if ();
    hex_display_scheduler_if req1_if ();

    hex_display_scheduler #(
        .MAX_BURST  (6),
        .BLANK_CODE (7'h7F)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .req0          (req0_if),
        .req1          (req1_if),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5),
        .owner         (owner),
        .err_pulse     (err_pulse)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic [6:0] exp_hex [6];
    logic [6:0] obs_hex [6];
    always_comb begin
        obs_hex[0] = hex0;
        obs_hex[1] = hex1;
        obs_hex[2] = hex2;
        obs_hex[3] = hex3;
        obs_hex[4] = hex4;
        obs_hex[5] = hex5;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check_all_hex(input string tag);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("%s_hex%0d", tag, k), 32'(obs_hex[k]), 32'(exp_hex[k]));
        end
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
        step();
        step();
        reset_reset_n = 1'b1;
        for (int k = 0; k < 6; k++) exp_hex[k] = 7'h7F;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int idx;
    int cyc;
    int acc_cyc [8];
    logic acc;

    initial begin
        req0_if.valid = 1'b0; req0_if.digit = 3'd0; req0_if.value = 4'd0; req0_if.blank = 1'b0;
        req1_if.valid = 1'b0; req1_if.digit = 3'd0; req1_if.value = 4'd0; req1_if.blank = 1'b0;
        reset_reset_n = 1'b0;

        // Reset then idle.
        do_reset();
        step();
        check_all_hex("rst");
        check_eq("rst_owner", 32'(owner), 32'd0);
        check_eq("rst_rdy0", 32'(req0_if.ready), 32'd0);
        check_eq("rst_rdy1", 32'(req1_if.ready), 32'd0);
        check_eq("rst_err", 32'(err_pulse), 32'd0);

        // Single req0 beat: digit 2 = A.
        req0_if.valid = 1'b1; req0_if.digit = 3'd2; req0_if.value = 4'hA; req0_if.blank = 1'b0;
        check_eq("single_idle_rdy0", 32'(req0_if.ready), 32'd0);
        step();
        check_eq("single_owner", 32'(owner), 32'd1);
        check_eq("single_rdy0", 32'(req0_if.ready), 32'd1);
        check_eq("single_rdy1", 32'(req1_if.ready), 32'd0);
        step();
        check_eq("single_hex2", 32'(hex2), 32'h08);
        req0_if.valid = 1'b0;
        step();
        check_eq("single_release", 32'(owner), 32'd0);

        // Both valid after reset: req0 first, idle gap, then req1.
        do_reset();
        req0_if.valid = 1'b1; req1_if.valid = 1'b1;
        req1_if.digit = 3'd4; req1_if.value = 4'h0;
        step();
        check_eq("rr_first_owner", 32'(owner), 32'd1);
        check_eq("rr_first_rdy1", 32'(req1_if.ready), 32'd0);
        req0_if.valid = 1'b0;
        step();
        check_eq("rr_gap_owner", 32'(owner), 32'd0);
        check_eq("rr_gap_rdy1", 32'(req1_if.ready), 32'd0);
        step();
        check_eq("rr_second_owner", 32'(owner), 32'd2);
        check_eq("rr_second_rdy1", 32'(req1_if.ready), 32'd1);
        req1_if.valid = 1'b0;
        step();
        check_eq("rr_second_release", 32'(owner), 32'd0);
        check_all_hex("rr");

        // req0 streams 8 beats; burst limit forces a release after 6.
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            req0_if.valid = 1'b1;
            req0_if.digit = 3'(idx % 6);
            req0_if.value = 4'(idx + 1);
            req0_if.blank = 1'b0;
            acc = req0_if.valid && req0_if.ready;
            if (acc) acc_cyc[idx] = cyc;
            step();
            if (acc) idx++;
            cyc++;
        end
        req0_if.valid = 1'b0;
        check_eq("burst_beats", 32'(idx), 32'd8);
        check_eq("burst_first6_span", 32'(acc_cyc[5] - acc_cyc[0]), 32'd5);
        check_eq("burst_regrant_gap", 32'(acc_cyc[6] - acc_cyc[5]), 32'd2);
        exp_hex[0] = 7'h78; exp_hex[1] = 7'h00; exp_hex[2] = 7'h30;
        exp_hex[3] = 7'h19; exp_hex[4] = 7'h12; exp_hex[5] = 7'h02;
        check_all_hex("burst");
        step();
        check_eq("burst_release", 32'(owner), 32'd0);

        // Illegal digit 7 from req1: error pulse, no digit change, beat counted.
        req1_if.valid = 1'b1; req1_if.digit = 3'd7; req1_if.value = 4'h3; req1_if.blank = 1'b0;
        step();
        check_eq("err_owner", 32'(owner), 32'd2);
        check_eq("err_pre", 32'(err_pulse), 32'd0);
        step();
        check_eq("err_pulse", 32'(err_pulse), 32'd1);
        check_all_hex("err");
        req1_if.digit = 3'd5; req1_if.value = 4'hC;
        step();
        check_eq("err_one_cycle", 32'(err_pulse), 32'd0);
        step();
        step();
        step();
        check_eq("err_count5_owner", 32'(owner), 32'd2);
        step();
        check_eq("err_count6_owner", 32'(owner), 32'd0);
        check_eq("err_count6_rdy1", 32'(req1_if.ready), 32'd0);
        exp_hex[5] = 7'h46;
        check_eq("err_hex5", 32'(hex5), 32'h46);
        req1_if.valid = 1'b0;
        step();

        // Blank beat on digit 0, then reset during a req1 burst.
        req0_if.valid = 1'b1; req0_if.digit = 3'd0; req0_if.value = 4'h5; req0_if.blank = 1'b1;
        step();
        check_eq("blank_owner", 32'(owner), 32'd1);
        step();
        check_eq("blank_hex0", 32'(hex0), 32'h7F);
        req0_if.valid = 1'b0; req0_if.blank = 1'b0;
        step();
        req1_if.valid = 1'b1; req1_if.digit = 3'd1; req1_if.value = 4'h9; req1_if.blank = 1'b0;
        step();
        check_eq("midrst_owner", 32'(owner), 32'd2);
        step();
        check_eq("midrst_hex1", 32'(hex1), 32'h10);
        req1_if.digit = 3'd2; req1_if.value = 4'hF;
        reset_reset_n = 1'b0;
        step();
        for (int k = 0; k < 6; k++) exp_hex[k] = 7'h7F;
        check_all_hex("midrst");
        check_eq("midrst_owner_rst", 32'(owner), 32'd0);
        check_eq("midrst_rdy0", 32'(req0_if.ready), 32'd0);
        check_eq("midrst_rdy1", 32'(req1_if.ready), 32'd0);
        check_eq("midrst_err", 32'(err_pulse), 32'd0);
        reset_reset_n = 1'b1;
        req1_if.valid = 1'b0;
        step();
        check_eq("midrst_after_owner", 32'(owner), 32'd0);
        check_eq("midrst_after_hex2", 32'(hex2), 32'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
